pll_reset_ctrl: RTL
===================

PLL_RESET_CTRL -- requirements
Module: pll_reset_ctrl

Interface
REQ-001 Parameter RST_CYCLES, default 16: cycles pll_reset is held high per reset pulse, range 1..65535.
REQ-002 Parameter LOCK_STABLE_CYCLES, default 1024: consecutive synchronized-lock cycles required before release, range 1..65535.
REQ-003 Parameter LOCK_TIMEOUT_CYCLES, default 50000: cycles allowed in WAIT_LOCK before the PLL is reset again, range 1..65535.
REQ-004 The block SHALL have one clock and an asynchronous active-low reset; all state SHALL be clocked on the rising edge of clkin.
REQ-005 clkin  input  1  free-running input reference clock (the clock that also feeds the PLL).
REQ-006 reset_n  input  1  asynchronous active-low reset.
REQ-007 pll_lock  input  1  PLL LOCK output, asynchronous to clkin.
REQ-008 pll_reset  output  1  active-high PLL reset, to the PLL RESET pin.
REQ-009 sys_rst_n  output  1  active-low reset for logic clocked by the PLL output.
REQ-010 pll_ready  output  1  high while state is RUN.
REQ-011 lock_lost  output  1  one-cycle pulse when lock drops in RUN.
REQ-012 relock_cnt  output  8  count of lock timeouts and lock losses, saturating.

Function
REQ-013 pll_lock SHALL pass through a 2-flop synchronizer; lock_s (the second flop) is the only lock signal used internally.
REQ-014 FSM states SHALL be RESET_PLL, WAIT_LOCK, STABLE and RUN, with one 16-bit counter cnt that is cleared on every state change.
REQ-015 RESET_PLL: pll_reset=1; after RST_CYCLES cycles in this state -> WAIT_LOCK.
REQ-016 WAIT_LOCK: pll_reset=0; lock_s=1 -> STABLE; otherwise, after LOCK_TIMEOUT_CYCLES cycles -> RESET_PLL and relock_cnt increments.
REQ-017 STABLE: lock_s=0 -> WAIT_LOCK, which restarts the timeout; LOCK_STABLE_CYCLES consecutive cycles with lock_s=1 -> RUN.
REQ-018 RUN: sys_rst_n=1 and pll_ready=1; lock_s=0 -> lock_lost pulses for one cycle and sys_rst_n=0 and pll_ready=0 from the next cycle.
REQ-019 All outputs SHALL be registered and decoded from the next state, so that sys_rst_n and pll_ready rise in the first RUN cycle.
REQ-020 pll_lock rising (stable) -> sys_rst_n SHALL rise exactly 2+LOCK_STABLE_CYCLES clkin edges after the first edge that samples pll_lock high in WAIT_LOCK.
REQ-021 relock_cnt SHALL saturate at 255 and never wrap; it is cleared only by reset_n.
REQ-022 A lock glitch of one cycle in STABLE SHALL restart qualification from WAIT_LOCK and SHALL NOT increment relock_cnt.
REQ-023 If a timeout and lock_s=1 occur in the same cycle in WAIT_LOCK, lock_s SHALL win (-> STABLE).

Reset
REQ-024 reset_n low SHALL immediately force: state RESET_PLL, cnt=0, pll_reset=1, sys_rst_n=0, pll_ready=0, lock_lost=0, relock_cnt=0, synchronizer flops=0.
REQ-025 reset_n asserted mid-operation (any state) SHALL behave identically to power-on reset; deassertion starts a full RST_CYCLES pulse.

Configuration
REQ-026 Macro PLL_RELOCK_EN defined: lock loss in RUN -> RESET_PLL, relock_cnt increments, and the full sequence repeats.
REQ-027 PLL_RELOCK_EN undefined: lock loss in RUN -> lock_lost pulse, sys_rst_n and pll_ready are held low, state is STAY (terminal, pll_reset=0), relock_cnt increments; only reset_n recovers.

Verification
REQ-028 Parameters 4/8/100; pll_lock rises 20 cycles after reset_n release -> pll_reset high for cycles 0-3, then sys_rst_n and pll_ready rise 10 edges after pll_lock is first sampled; relock_cnt=0.
REQ-029 pll_lock held low -> pll_reset re-pulses 4 cycles every 104 cycles; relock_cnt reaches 3 after 3 timeouts; after 300 timeouts relock_cnt=255.
REQ-030 pll_lock high, then low for 1 cycle at STABLE cnt=5, then high -> no RUN until 8 more consecutive cycles; relock_cnt unchanged.
REQ-031 In RUN, pll_lock drops -> lock_lost is a single-cycle pulse, sys_rst_n goes low the next cycle; with PLL_RELOCK_EN, pll_reset pulses and relock_cnt=1; without it, the block stays in STAY with pll_reset=0.
REQ-032 reset_n asserted in RUN for 1 cycle -> all outputs return to reset values asynchronously, then the full sequence repeats.

Source files
------------

// File: rtl/pll_reset_ctrl.sv
// PLL reset sequencer: pulses the PLL reset, qualifies a synchronized lock, then releases the system reset.
// Define PLL_RELOCK_EN to re-run the full sequence on lock loss; otherwise lock loss is terminal until reset_n.
module pll_reset_ctrl #(
    parameter int unsigned RST_CYCLES          = 16,
    parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 50000
) (
    input  logic       clkin,
    input  logic       reset_n,
    input  logic       pll_lock,
    output logic       pll_reset,
    output logic       sys_rst_n,
    output logic       pll_ready,
    output logic       lock_lost,
    output logic [7:0] relock_cnt
);

    typedef enum logic [2:0] {
        RESET_PLL = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        STAY      = 3'd4
    } state_e;

    localparam logic [15:0] RST_LAST     = 16'(RST_CYCLES - 1);
    localparam logic [15:0] STABLE_LAST  = 16'(LOCK_STABLE_CYCLES - 1);
    localparam logic [15:0] TIMEOUT_LAST = 16'(LOCK_TIMEOUT_CYCLES - 1);

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        sync1_q;
    logic        lock_s_q;
    logic [7:0]  relock_q, relock_d;
    logic        relock_inc;
    logic        pll_reset_q, pll_reset_d;
    logic        sys_rst_n_q, sys_rst_n_d;
    logic        pll_ready_q, pll_ready_d;
    logic        lock_lost_q, lock_lost_d;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        relock_inc  = 1'b0;
        lock_lost_d = 1'b0;

        case (state_q)
            RESET_PLL: begin
                cnt_d = cnt_q + 16'd1;
                if (cnt_q == RST_LAST) state_d = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                cnt_d = cnt_q + 16'd1;
                // A lock seen on the timeout cycle takes priority over re-resetting the PLL.
                if (lock_s_q) begin
                    state_d = STABLE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d    = RESET_PLL;
                    relock_inc = 1'b1;
                end
            end
            STABLE: begin
                cnt_d = cnt_q + 16'd1;
                if (!lock_s_q)                 state_d = WAIT_LOCK;
                else if (cnt_q == STABLE_LAST) state_d = RUN;
            end
            RUN: begin
                if (!lock_s_q) begin
                    lock_lost_d = 1'b1;
                    relock_inc  = 1'b1;
`ifdef PLL_RELOCK_EN
                    state_d     = RESET_PLL;
`else
                    state_d     = STAY;
`endif
                end
            end
            STAY: begin
                state_d = STAY;
            end
            default: begin
                state_d = RESET_PLL;
            end
        endcase

        if (state_d != state_q) cnt_d = '0;

        relock_d = (relock_inc && (relock_q != 8'hFF)) ? relock_q + 8'd1 : relock_q;

        // Outputs decode the next state so they change on the same edge as the state.
        pll_reset_d = (state_d == RESET_PLL);
        sys_rst_n_d = (state_d == RUN);
        pll_ready_d = (state_d == RUN);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together on the edge.
    always_ff @(posedge clkin or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= RESET_PLL;
            cnt_q       <= '0;
            sync1_q     <= 1'b0;
            lock_s_q    <= 1'b0;
            relock_q    <= '0;
            pll_reset_q <= 1'b1;
            sys_rst_n_q <= 1'b0;
            pll_ready_q <= 1'b0;
            lock_lost_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sync1_q     <= pll_lock;
            lock_s_q    <= sync1_q;
            relock_q    <= relock_d;
            pll_reset_q <= pll_reset_d;
            sys_rst_n_q <= sys_rst_n_d;
            pll_ready_q <= pll_ready_d;
            lock_lost_q <= lock_lost_d;
        end
    end

    assign pll_reset  = pll_reset_q;
    assign sys_rst_n  = sys_rst_n_q;
    assign pll_ready  = pll_ready_q;
    assign lock_lost  = lock_lost_q;
    assign relock_cnt = relock_q;

endmodule
